// File: rtl/td4_pkg.sv
// Shared TD4 definitions: program address space geometry and the loader FSM
// state encoding used by prog_loader.
package td4_pkg;
  localparam int TD4_DEPTH = 16;
  localparam int TD4_AW    = 4;
  localparam int TD4_DW    = 8;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, ERR} loader_state_t;
endpackage

// File: rtl/prog_loader_if.sv
// Byte-wide valid/ready program stream into prog_loader.
//   in_valid : producer has a byte on in_data
//   in_data  : program byte or trailing checksum byte
//   in_ready : loader accepts in_data this cycle
// master = byte producer, slave = prog_loader.
interface prog_loader_if #(parameter int DW = td4_pkg::TD4_DW) ();
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/prog_ram.sv
// Program storage: DEPTH x DW, one synchronous write port, one
// combinational read port. No reset; contents undefined until written.
//   clk            : write clock
//   we/waddr/wdata : write port (visible on d the cycle after)
//   addr/d         : combinational read port (same-cycle write returns old data)
module prog_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] d
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign d = mem[addr];
endmodule

// File: rtl/prog_loader.sv
// Writable replacement for the TD4 program ROM. Accepts DEPTH program bytes
// (plus an optional two's-complement checksum byte) over a valid/ready
// stream, writes them into prog_ram and holds the core in reset meanwhile.
//   clk, reset : clock, synchronous active-high reset
//   start      : pulse that begins or restarts a load (beats a same-cycle byte)
//   s          : program byte stream (slave side)
//   addr, d    : core fetch port, combinational
//   cpu_hold   : core held in reset (LOAD, CHECK, ERR)
//   busy       : load in progress (LOAD, CHECK)
//   done, err  : sticky result of the last load
module prog_loader
  import td4_pkg::*;
#(
  parameter int DEPTH       = TD4_DEPTH,
  parameter int AW          = TD4_AW,
  parameter int DW          = TD4_DW,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  prog_loader_if.slave  s,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] d,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);
  loader_state_t state_q, state_n;
  logic [AW-1:0] wptr_q, wptr_n;
  logic [DW-1:0] sum_q, sum_n, sum_add;
  logic          done_n, err_n;
  logic          hs, we;

  // Status outputs decode registered state only.
  assign s.in_ready = (state_q == LOAD) || (state_q == CHECK);
  assign busy       = s.in_ready;
  assign cpu_hold   = (state_q != IDLE);

  assign hs      = s.in_valid && s.in_ready;
  assign sum_add = sum_q + s.in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      sum_q   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      wptr_q  <= wptr_n;
      sum_q   <= sum_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    wptr_n  = wptr_q;
    sum_n   = sum_q;
    done_n  = done;
    err_n   = err;
    we      = 1'b0;
    if (start) begin
      // Any state: (re)start a load from the first byte; a same-cycle byte
      // is dropped.
      state_n = LOAD;
      wptr_n  = '0;
      sum_n   = '0;
      done_n  = 1'b0;
      err_n   = 1'b0;
    end else if (hs) begin
      if (state_q == LOAD) begin
        we     = 1'b1;
        sum_n  = sum_add;
        wptr_n = wptr_q + 1'b1;
        if (wptr_q == AW'(DEPTH - 1)) begin
          if (CHECKSUM_EN) state_n = CHECK;
          else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end else begin
        // CHECK: checksum byte is consumed but never stored.
        if (sum_add == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = ERR;
          err_n   = 1'b1;
        end
      end
    end
  end

  prog_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata (s.in_data),
    .addr  (addr),
    .d     (d)
  );
endmodule
